sync_fifo_prog: RTL
===================

Name: sync_fifo_prog

Overview:
- Parametrised synchronous FIFO; next generation of the team's 8-bit, 16-deep FIFO.
- Generalises data width, depth and almost-full/almost-empty thresholds.
- Adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count, synchronous flush, and sticky overflow/underflow error flags.
- Single-clock buffer between a producer and a consumer on the same clock; fits the existing driver/monitor bench with the extra pins added.

Parameters:
- DATA_WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of 2, >=4.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value (1..DEPTH-1).
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value (1..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request / pop.
- data_out  out  DATA_WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  clears sticky error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-operation):
  - Pointers and count cleared.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - data_out=0, overflow=0, underflow=0.
  - Memory array is not reset.
- Write acceptance: wr_en && !full, using the pre-edge value of full. The word is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Read acceptance: rd_en && !empty, using the pre-edge value of empty. rd_ptr increments, wrapping modulo DEPTH.
- Pointer width is $clog2(DEPTH); wrap is natural binary rollover.
- count update each edge: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither are accepted.
- Flags full, empty, almost_full and almost_empty decode combinationally from registered count, so they change in the same cycle as count.
- Simultaneous rd_en && wr_en:
  - When full: read accepted, write rejected; overflow sets and count becomes DEPTH-1.
  - When empty: write accepted, read rejected; underflow sets and count becomes 1.
  - Otherwise both are accepted and count is unchanged.
- FWFT=0 read timing: on an accepted read, data_out registers mem[rd_ptr] at that edge (1-cycle latency). data_out holds its value when no read is accepted.
- FWFT=1 read timing:
  - data_out = mem[rd_ptr] whenever empty=0, and 0 when empty=1.
  - rd_en pops the current head; the next head is visible after the edge.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Error flags:
  - overflow sets on the edge where wr_en && full; underflow sets on the edge where rd_en && empty.
  - Both stay set until clr_err=1 at an edge.
  - If clr_err and a new error occur in the same cycle, set wins.
- flush=1 at an edge:
  - Pointers and count go to 0, and wr_en/rd_en in that cycle are ignored.
  - No error flags are set by that cycle's wr_en/rd_en.
  - data_out goes to 0 in both modes.
  - Existing sticky flags are retained.
- Read-during-write to the same address cannot occur: an accepted read and write in the same cycle need a non-empty FIFO, and rd_ptr==wr_ptr then means full, where the write is rejected.

Test Plan:
- FWFT=0, DEPTH=16: after reset, write 0x00..0x0F on 16 consecutive cycles -> count=16, full=1 and almost_full=1 (from count 14); 17th write of 0xAA -> overflow=1, count stays 16, 0xAA never read back.
- FWFT=0: from full, read 16 cycles -> data_out 0x00..0x0F, each one cycle after its rd_en edge; empty=1 after the last; one further rd_en -> underflow=1, data_out holds 0x0F; clr_err pulse -> both flags 0.
- Wrap and concurrency: preload 8 words, then 40 cycles of simultaneous rd_en/wr_en with incrementing data -> count stays 8 throughout, output is in-order with no loss, pointers wrap at least twice.
- FWFT=1: write 0x5C into an empty FIFO -> data_out=0x5C the next cycle with no rd_en; rd_en pops it -> empty=1, data_out=0. Simultaneous rd_en/wr_en while empty -> write accepted, underflow=1, count=1.
- flush with 10 entries, wr_en=1 in the same cycle -> count=0, empty=1, overflow/underflow unchanged; a following write then read returns only the new word.
- Assert reset_n low mid-burst at count=7, between clock edges -> all outputs reach reset values immediately without waiting for an edge; after release, normal writes resume from count 0.

Source files
------------

// File: rtl/sync_fifo_prog.sv
// =============================================================================
// sync_fifo_prog : parametrised single-clock FIFO with an optional FWFT read
//                  mode, occupancy count, flush, and sticky error flags.
// Revision       : 1.0
// =============================================================================
`default_nettype none

module sync_fifo_prog #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   parameter bit FWFT          = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [DATA_WIDTH-1:0]      data_in,
   output logic                       full,
   output logic                       almost_full,
   input  logic                       rd_en,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       empty,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic                       flush,
   input  logic                       clr_err,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     C_FULL   = (AW+1)'(DEPTH);
   localparam logic [AW:0]     C_AFULL  = (AW+1)'(AFULL_THRESH);
   localparam logic [AW:0]     C_AEMPTY = (AW+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_wr_ok;
   logic w_rd_ok;
   logic w_set_ovf;
   logic w_set_unf;

   assign full         = (r_count == C_FULL);
   assign empty        = (r_count == '0);
   assign almost_full  = (r_count >= C_AFULL);
   assign almost_empty = (r_count <= C_AEMPTY);
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // A flush cycle swallows both requests, so it can neither move data nor raise errors.
   assign w_wr_ok   = wr_en && !full  && !flush;
   assign w_rd_ok   = rd_en && !empty && !flush;
   assign w_set_ovf = wr_en && full   && !flush;
   assign w_set_unf = rd_en && empty  && !flush;

   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr_ok && !w_rd_ok) begin
            r_count <= r_count + 1'b1;
         end else if (w_rd_ok && !w_wr_ok) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // A new error in the same cycle as clr_err wins over the clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_set_ovf) begin
            r_overflow <= 1'b1;
         end else if (clr_err) begin
            r_overflow <= 1'b0;
         end
         if (w_set_unf) begin
            r_underflow <= 1'b1;
         end else if (clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out = empty ? '0 : mem[r_rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_data;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_data <= '0;
            end else if (flush) begin
               r_data <= '0;
            end else if (w_rd_ok) begin
               r_data <= mem[r_rd_ptr];
            end
         end

         assign data_out = r_data;
      end
   endgenerate

endmodule

`default_nettype wire
